// File: rtl/and2_sched_pkg.sv
// Shared types and elaboration-time helpers for the And2 chain scheduler.
package and2_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest chunk the lowest_zero helper can scan.
  localparam int MAX_STEP = 32;

  // Requester index width (IDW). Never zero, even for a single requester.
  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Zero-index width (ZW). Must also encode WIDTH, which means "no zero bit".
  function automatic int zidx_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Number of STEP-bit chunks in one operand (NCHUNK).
  function automatic int n_chunks(input int width, input int step);
    return width / step;
  endfunction

  // Width of the chunk counter. Never zero.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest zero among the low n bits, or n if they are all ones.
  function automatic int lowest_zero(input logic [MAX_STEP-1:0] bits, input int n);
    int r;
    r = n;
    // Scanning downwards leaves the lowest matching index in r.
    for (int i = MAX_STEP - 1; i >= 0; i--) begin
      if (i < n && !bits[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/and2_sched_rr_pick.sv
// Combinational round-robin picker: the first valid requester strictly after
// rr_ptr (wrapping) wins, so the last requester served gets the lowest priority.
module and2_sched_rr_pick
  import and2_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [IDW-1:0]   grant_idx,
  output logic             grant_any
);

  logic [IDW-1:0] cand;

  // Search rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ) and grant the first valid one.
  always_comb begin
    // NOTE: every output gets a default before the search, so no path through
    // the loop leaves one unassigned and no latch is inferred.
    grant_onehot = '0;
    grant_idx    = '0;
    grant_any    = 1'b0;
    cand         = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any          = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/and2_chain_scheduler.sv
// Time-shares one STEP-bit And2 reduction chain between N_REQ requesters.
// A granted WIDTH-bit operand is reduced LSB chunk first over WIDTH/STEP
// cycles; the result is the AND of all bits and the index of the lowest zero.
module and2_chain_scheduler
  import and2_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  parameter  int STEP  = 2,
  localparam int IDW   = id_width(N_REQ),
  localparam int ZW    = zidx_width(WIDTH)
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESETN,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic                   resp_O,
  output logic [ZW-1:0]          resp_zero_idx
);

  localparam int NCHUNK = n_chunks(WIDTH, STEP);
  localparam int CW     = cnt_width(NCHUNK);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  operand_q;
  logic [IDW-1:0]    id_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic              acc_q, acc_d;
  logic [ZW-1:0]     zidx_q, zidx_d;
  logic [CW-1:0]     chunk_q;
  logic              last_chunk;

  logic [N_REQ-1:0]  grant_onehot;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  logic              grant_fire;
  logic [WIDTH-1:0]  grant_data;

  logic [STEP-1:0]   chunk_bits;
  logic [STEP:0]     and_chain;
  logic              chunk_all_ones;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  and2_sched_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_valid    (req_valid),
    .rr_ptr       (rr_ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_any    (grant_any)
  );

  // Select the granted requester's operand from the flat input bus.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) grant_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign grant_fire = (state_q == IDLE) && grant_any;

  // ---------------------------------------------------------------------------
  // Shared STEP-bit And2 chain
  // ---------------------------------------------------------------------------
  // The operand register shifts right each BUSY cycle, so the chunk under
  // reduction is always its low STEP bits.
  assign chunk_bits   = operand_q[STEP-1:0];
  assign and_chain[0] = 1'b1;

  for (genvar i = 0; i < STEP; i++) begin : g_and2
    assign and_chain[i+1] = and_chain[i] & chunk_bits[i];
  end

  assign chunk_all_ones = and_chain[STEP];
  assign last_chunk     = (chunk_q == CW'(NCHUNK - 1));

  // Next accumulator and zero index; only the first zero found is kept.
  always_comb begin
    acc_d  = acc_q & chunk_all_ones;
    zidx_d = zidx_q;
    if (zidx_q == ZW'(WIDTH) && !chunk_all_ones) begin
      zidx_d = ZW'(int'(chunk_q) * STEP
                   + lowest_zero(MAX_STEP'(chunk_bits), STEP));
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!ASYNCRESETN) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic and the combinational grant.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        req_ready = grant_onehot;
        if (grant_any) state_d = BUSY;
      end
      BUSY: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        // The handshake cycle never grants: IDLE is only reached on the next edge.
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // Operand capture, chunk-by-chunk reduction, result latch and pointer update.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      // NOTE: the operand and accumulators are reset as well, so an in-flight
      // operand is dropped outright and every output is defined straight away.
      operand_q     <= '0;
      id_q          <= '0;
      acc_q         <= 1'b0;
      zidx_q        <= '0;
      chunk_q       <= '0;
      rr_ptr_q      <= IDW'(N_REQ - 1);
      resp_O        <= 1'b0;
      resp_id       <= '0;
      resp_zero_idx <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_fire) begin
            operand_q <= grant_data;
            id_q      <= grant_idx;
            acc_q     <= 1'b1;
            zidx_q    <= ZW'(WIDTH);
            chunk_q   <= '0;
          end
        end
        BUSY: begin
          operand_q <= operand_q >> STEP;
          acc_q     <= acc_d;
          zidx_q    <= zidx_d;
          chunk_q   <= chunk_q + CW'(1);
          if (last_chunk) begin
            resp_O        <= acc_d;
            resp_zero_idx <= zidx_d;
            resp_id       <= id_q;
          end
        end
        DONE: begin
          // The pointer only moves on completion, which is what prevents starvation.
          if (resp_ready) rr_ptr_q <= id_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interface properties
  // ---------------------------------------------------------------------------
  // At most one requester is granted, and only while idle.
  always_ff @(posedge CLK) begin
    if (ASYNCRESETN) begin
      assert ($onehot0(req_ready));
      assert (req_ready == '0 || state_q == IDLE);
    end
  end

  // A stalled response holds its payload.
  property p_resp_stable;
    @(posedge CLK) disable iff (!ASYNCRESETN)
      (resp_valid && !resp_ready) |=>
        (resp_valid && $stable(resp_O) && $stable(resp_id) && $stable(resp_zero_idx));
  endproperty
  a_resp_stable: assert property (p_resp_stable);

endmodule
